// File: rtl/inventario_pkg.sv
// inventario_pkg -- shared definitions for the inventario arbiter slice.
//   state_t          : 2-bit FSM state encoding (IDLE, GRANT_A, GRANT_B, EMPTY)
//   DEFAULT_CAPACITY : units held after reset or restock unless overridden
package inventario_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_A = 2'd1,
        GRANT_B = 2'd2,
        EMPTY   = 2'd3
    } state_t;

    localparam int DEFAULT_CAPACITY = 3;

endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2 -- two-way round-robin pick.
//   reqA, reqB   : requests from A and B
//   lastServedA  : 1 = A was served most recently, 0 = B (or nobody since reset)
//   pickA, pickB : one-hot choice (both 0 when nobody requests)
// On contention the requester that was not served last wins.
module rr_arbiter2 (
    input  logic reqA,
    input  logic reqB,
    input  logic lastServedA,
    output logic pickA,
    output logic pickB
);

    always_comb begin
        pickA = reqA && (!reqB || !lastServedA);
        pickB = reqB && (!reqA ||  lastServedA);
    end

endmodule

// File: rtl/inventario_arbiter.sv
// inventario_arbiter -- hands out units of a small inventory to two requesters.
//   clk1               : clock, rising edge
//   reset1             : synchronous active-low reset
//   reqA, reqB         : unit requests, held high until granted
//   restock            : one-cycle pulse refilling to CAPACITY
//                        (only honoured with INVENTARIO_RESTOCK_EN defined;
//                        otherwise ignored and EMPTY is terminal until reset)
//   gntA, gntB         : one-cycle grant pulses
//   denyA, denyB       : one-cycle pulses while requesting an empty inventory
//   count              : units remaining
//   endEmptyInventario : 1 while stock is available
// All outputs are registered. After a grant the FSM spends one cycle in
// GRANT_x without sampling requests, so at most one grant per two cycles.
module inventario_arbiter
    import inventario_pkg::*;
#(
    parameter int CAPACITY = DEFAULT_CAPACITY,
    parameter int CNT_W    = 2
) (
    input  logic             clk1,
    input  logic             reset1,
    input  logic             reqA,
    input  logic             reqB,
    input  logic             restock,
    output logic             gntA,
    output logic             gntB,
    output logic             denyA,
    output logic             denyB,
    output logic [CNT_W-1:0] count,
    output logic             endEmptyInventario
);

    localparam logic [CNT_W-1:0] CAP_VAL = CNT_W'(CAPACITY);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

    state_t state;
    logic   lastServedA;
    logic   pickA;
    logic   pickB;

    rr_arbiter2 rrPick (
        .reqA        (reqA),
        .reqB        (reqB),
        .lastServedA (lastServedA),
        .pickA       (pickA),
        .pickB       (pickB)
    );

`ifndef INVENTARIO_RESTOCK_EN
    logic unusedRestock;
    assign unusedRestock = restock;
`endif

    always_ff @(posedge clk1) begin
        if (!reset1) begin
            state              <= IDLE;
            count              <= CAP_VAL;
            endEmptyInventario <= 1'b1;
            gntA               <= 1'b0;
            gntB               <= 1'b0;
            denyA              <= 1'b0;
            denyB              <= 1'b0;
            lastServedA        <= 1'b0;
        end else begin
            gntA  <= 1'b0;
            gntB  <= 1'b0;
            denyA <= 1'b0;
            denyB <= 1'b0;
`ifdef INVENTARIO_RESTOCK_EN
            // Restock outranks any request this cycle; the round-robin
            // pointer is left alone so fairness carries across refills.
            if (restock) begin
                state              <= IDLE;
                count              <= CAP_VAL;
                endEmptyInventario <= 1'b1;
            end else
`endif
            begin
                case (state)
                    IDLE: begin
                        if (count == '0) begin
                            state <= EMPTY;
                        end else if (pickA || pickB) begin
                            state              <= pickA ? GRANT_A : GRANT_B;
                            gntA               <= pickA;
                            gntB               <= pickB;
                            lastServedA        <= pickA;
                            count              <= count - ONE;
                            // Flag tracks the post-decrement count on the same edge.
                            endEmptyInventario <= (count != ONE);
                        end
                    end
                    GRANT_A, GRANT_B: begin
                        state <= (count == '0) ? EMPTY : IDLE;
                    end
                    EMPTY: begin
                        denyA <= reqA;
                        denyB <= reqB;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_inventario_arbiter.sv
// tb_inventario_arbiter -- scoreboard bench for inventario_arbiter.
// Two instances share stimulus: the default configuration and CAPACITY=1.
// A stock-count reference model predicts every cycle's outputs.
module tb_inventario_arbiter;

`ifdef INVENTARIO_RESTOCK_EN
    localparam bit RESTOCK_EN = 1'b1;
`else
    localparam bit RESTOCK_EN = 1'b0;
`endif

    typedef struct packed {
        logic       gA;
        logic       gB;
        logic       dA;
        logic       dB;
        logic [1:0] cnt;
        logic       ne;
    } out_t;

    typedef struct packed {
        out_t m;
        out_t s;
    } exp_t;

    typedef struct {
        int stock;
        bit cool;   // a grant happened last cycle; requests ignored now
        bit lastA;  // A received the most recent grant
    } mstate_t;

    logic       clk1 = 1'b0;
    logic       reset1 = 1'b0;
    logic       reqA = 1'b0;
    logic       reqB = 1'b0;
    logic       restock = 1'b0;

    logic       gntAM, gntBM, denyAM, denyBM, neM;
    logic [1:0] countM;
    logic       gntAS, gntBS, denyAS, denyBS, neS;
    logic [1:0] countS;

    int   errors = 0;
    int   checks = 0;
    exp_t q[$];

    mstate_t ms = '{default: 0};
    mstate_t ss = '{default: 0};

    always #5 clk1 = ~clk1;

    inventario_arbiter #(.CAPACITY(3), .CNT_W(2)) dutMain (
        .clk1               (clk1),
        .reset1             (reset1),
        .reqA               (reqA),
        .reqB               (reqB),
        .restock            (restock),
        .gntA               (gntAM),
        .gntB               (gntBM),
        .denyA              (denyAM),
        .denyB              (denyBM),
        .count              (countM),
        .endEmptyInventario (neM)
    );

    inventario_arbiter #(.CAPACITY(1), .CNT_W(2)) dutCap1 (
        .clk1               (clk1),
        .reset1             (reset1),
        .reqA               (reqA),
        .reqB               (reqB),
        .restock            (restock),
        .gntA               (gntAS),
        .gntB               (gntBS),
        .denyA              (denyAS),
        .denyB              (denyBS),
        .count              (countS),
        .endEmptyInventario (neS)
    );

    // Reference: stock is handed out one unit at a time, never faster than
    // every other cycle; an empty stock turns each request into a deny.
    function automatic out_t step(inout mstate_t s, input bit rA, input bit rB,
                                  input bit rs, input bit rst, input int cap);
        out_t o;
        bit giveA;
        o = '0;
        if (!rst) begin
            s.stock = cap;
            s.cool  = 1'b0;
            s.lastA = 1'b0;
        end else if (RESTOCK_EN && rs) begin
            s.stock = cap;
            s.cool  = 1'b0;
        end else if (s.cool) begin
            s.cool = 1'b0;
        end else if (s.stock == 0) begin
            o.dA = rA;
            o.dB = rB;
        end else if (rA || rB) begin
            giveA   = rA && (!rB || !s.lastA);
            o.gA    = giveA;
            o.gB    = !giveA;
            s.stock = s.stock - 1;
            s.cool  = 1'b1;
            s.lastA = giveA;
        end
        o.cnt = 2'(s.stock);
        o.ne  = (s.stock != 0);
        return o;
    endfunction

    task automatic drive(input bit a, input bit b, input bit rs, input bit rst,
                         output out_t om);
        exp_t e;
        @(negedge clk1);
        reqA    = a;
        reqB    = b;
        restock = rs;
        reset1  = rst;
        e.m = step(ms, a, b, rs, rst, 3);
        e.s = step(ss, a, b, rs, rst, 1);
        om  = e.m;
        @(posedge clk1);
        #1;
        q.push_back(e);
    endtask

    task automatic compare(input string name, input out_t act, input out_t exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s t=%0t got gA=%b gB=%b dA=%b dB=%b cnt=%0d ne=%b expected gA=%b gB=%b dA=%b dB=%b cnt=%0d ne=%b",
                     name, $time, act.gA, act.gB, act.dA, act.dB, act.cnt, act.ne,
                     exp.gA, exp.gB, exp.dA, exp.dB, exp.cnt, exp.ne);
        end
    endtask

    // Monitor: outputs are presented every cycle, so one entry per cycle.
    always @(negedge clk1) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            compare("main", {gntAM, gntBM, denyAM, denyBM, countM, neM}, e.m);
            compare("cap1", {gntAS, gntBS, denyAS, denyBS, countS, neS}, e.s);
        end
    end

    initial begin
        out_t o;
        bit   pendA;
        bit   pendB;
        bit   rst;
        bit   rs;

        drive(0, 0, 0, 0, o);
        drive(0, 0, 0, 0, o);
        // Single request from A, then quiet.
        drive(1, 0, 0, 1, o);
        drive(0, 0, 0, 1, o);
        drive(0, 0, 0, 1, o);
        // Both held: alternate grants until empty, then denies.
        repeat (9) drive(1, 1, 0, 1, o);
        // Restock with B requesting, B keeps requesting.
        drive(0, 1, 1, 1, o);
        repeat (4) drive(0, 1, 0, 1, o);
        // Reset while in GRANT_B, then contention shows A priority again.
        drive(0, 0, 0, 0, o);
        drive(0, 1, 0, 1, o);
        drive(0, 0, 0, 0, o);
        drive(1, 1, 0, 1, o);
        drive(0, 0, 0, 1, o);
        // Requesters hold until granted; random restocks and resets.
        pendA = 1'b0;
        pendB = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (!pendA) pendA = ($urandom_range(0, 1) == 1);
            if (!pendB) pendB = ($urandom_range(0, 1) == 1);
            rst = ($urandom_range(0, 39) != 0);
            rs  = ($urandom_range(0, 14) == 0);
            drive(pendA, pendB, rs, rst, o);
            if (o.gA) pendA = 1'b0;
            if (o.gB) pendB = 1'b0;
            if (!rst) begin
                pendA = 1'b0;
                pendB = 1'b0;
            end
        end
        drive(0, 0, 0, 1, o);
        for (int i = 0; i < 5 && q.size() > 0; i++) @(negedge clk1);
        #1;
        if (q.size() > 0) begin
            checks = checks + 1;
            errors = errors + 1;
            $display("FAIL drain pending=%0d required=0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/inventario_arbiter.md
INVENTARIO_ARBITER -- requirements
Module: inventario_arbiter

Interface
REQ-001 The block SHALL have parameter CAPACITY, default 3, meaning the number of units held after reset or restock (1..2**CNT_W-1).
REQ-002 The block SHALL have parameter CNT_W, default 2, meaning the width of the unit counter.
REQ-003 The block SHALL have port clk1  input  1  the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset1  input  1  reset, synchronous and active-low (0 = reset, sampled on posedge clk1).
REQ-005 The block SHALL have port reqA  input  1  requester A wants one unit; held high until granted.
REQ-006 The block SHALL have port reqB  input  1  requester B wants one unit; held high until granted.
REQ-007 The block SHALL have port restock  input  1  one-cycle pulse refilling the inventory to CAPACITY.
REQ-008 The block SHALL have port gntA  output  1  one-cycle pulse; one unit given to A.
REQ-009 The block SHALL have port gntB  output  1  one-cycle pulse; one unit given to B.
REQ-010 The block SHALL have port denyA  output  1  one-cycle pulse; A requested while the inventory is empty.
REQ-011 The block SHALL have port denyB  output  1  one-cycle pulse; B requested while the inventory is empty.
REQ-012 The block SHALL have port count  output  CNT_W  units remaining.
REQ-013 The block SHALL have port endEmptyInventario  output  1  1 = stock available, 0 = empty.

Function
REQ-014 The block SHALL implement FSM states IDLE, GRANT_A, GRANT_B, EMPTY; all outputs are registered.
REQ-015 In IDLE with count>0 and exactly one request high, the block SHALL go to GRANT_x, pulse gntx and decrement count on the same edge, giving 1-cycle latency from request sample to grant.
REQ-016 In IDLE with both requests high, the block SHALL grant the requester not served last (round-robin); after reset A has priority.
REQ-017 From GRANT_x the block SHALL go to EMPTY if count==0, else IDLE; requests are not sampled in GRANT_x, so one grant occurs per two cycles at most.
REQ-018 In EMPTY the block SHALL issue no grants, pulse denyx for one cycle for each cycle reqx is high, and hold count=0.
REQ-019 endEmptyInventario SHALL equal (count!=0) and update on the same edge as count.
REQ-020 count SHALL never underflow below 0 nor exceed CAPACITY.
REQ-021 restock SHALL load count=CAPACITY and go to IDLE from any state; restock coinciding with a request wins, giving no grant or deny that cycle, and the request is served later.
REQ-022 Restock while count>0 SHALL saturate at CAPACITY; the round-robin pointer is unchanged.

Reset
REQ-023 reset1=0 at a clock edge SHALL force state=IDLE, count=CAPACITY, endEmptyInventario=1, gntA=gntB=denyA=denyB=0, and round-robin pointer=A, overriding all inputs including an in-progress grant.

Configuration
REQ-024 With macro INVENTARIO_RESTOCK_EN defined, restock SHALL behave per REQ-021/022.
REQ-025 Without INVENTARIO_RESTOCK_EN, the restock port SHALL remain but be ignored; EMPTY is terminal until reset.

Structure
REQ-026 Package inventario_pkg SHALL hold the FSM state encoding (2-bit) and the default CAPACITY constant.
REQ-027 Round-robin selection SHALL be one sub-module rr_arbiter2 (inputs reqA, reqB, last-served bit; outputs one-hot pick).

Verification
REQ-028 Reset, then reqA high for 1 cycle -> next cycle gntA=1, count 3->2, endEmptyInventario=1.
REQ-029 reqA and reqB held high -> grants alternate A,B,A on alternate cycles; count 3,2,1,0; then EMPTY, endEmptyInventario=0, denyA/denyB pulse each cycle.
REQ-030 In EMPTY, restock pulse with reqB high -> no deny that cycle, count=3, next IDLE sample gives gntB (macro defined); without macro, count stays 0 and denyB continues.
REQ-031 reset1=0 asserted during GRANT_B -> next edge gntB=0, count=3, state IDLE, A priority restored.
REQ-032 CAPACITY=1, reqB -> gntB, count=0, endEmptyInventario=0 on the same edge; subsequent reqA -> denyA only.
